// File: rtl/irq_timer_if.sv
// Register-bus interface for the irq_timer slave: word-select address,
// write strobe/data, combinational read data and the interrupt request.
interface irq_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer acting as the CPU interrupt source.
// Registers: 0 = CTRL {IM, MODE[1:0], EN}, 1 = PRESET, 2 = COUNT (read-only),
// 3 = reserved (reads 0). irq = irq_flag & CTRL.IM.
// Optional feature macro: TIMER_PRESCALE_EN enables an 8-bit prescaler so
// COUNT decrements once every PRESCALE cycles instead of every cycle.
module irq_timer #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  irq_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

  if ((PRESCALE < 1) || (PRESCALE > 255)) begin : g_bad_prescale
    $error("irq_timer: PRESCALE must be in 1..255");
  end

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        tick;
  logic        ctrl_wr;
  logic        preset_wr;

  assign ctrl_wr   = bus.we && (bus.addr == 2'd0);
  assign preset_wr = bus.we && (bus.addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] pre_q, pre_d;

  // Prescaler: runs only while counting, restarts from zero on every other state
  always_comb begin
    pre_d = '0;
    tick  = 1'b0;
    if (state_q == S_CNT) begin
      if (pre_q == 8'(PRESCALE - 1)) begin
        tick = 1'b1;
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end
  end

  // Prescaler register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state logic: FSM first, then bus writes so the written CTRL value
  // overrides the INT-state EN clear, while an FSM flag set beats the
  // CTRL-write acknowledge so no interrupt is lost.
  always_comb begin
    logic flag_set;
    logic flag_clr;
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_set = 1'b0;
    flag_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q <= 32'd1) begin
            count_d  = '0;
            flag_set = 1'b1;
            state_d  = S_INT;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      S_INT: begin
        if (mode_q == MODE_RELOAD) begin
          count_d  = preset_q;
          flag_clr = 1'b1;
          state_d  = S_CNT;
        end else begin
          en_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ctrl_wr) begin
      en_d     = bus.wdata[0];
      mode_d   = bus.wdata[2:1];
      im_d     = bus.wdata[3];
      flag_clr = 1'b1;
    end
    if (preset_wr) begin
      preset_d = bus.wdata;
    end

    if (flag_set)      flag_d = 1'b1;
    else if (flag_clr) flag_d = 1'b0;
    else               flag_d = flag_q;
  end

  // State and register file update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= '0;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Combinational register read and interrupt output
  always_comb begin
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, im_q, mode_q, en_q};
      2'd1:    bus.rdata = preset_q;
      2'd2:    bus.rdata = count_q;
      default: bus.rdata = '0;
    endcase
    bus.irq = flag_q & im_q;
  end

endmodule

// File: tb/tb_irq_timer.sv
// Self-checking bench for irq_timer. Per-cycle expectations (COUNT, irq) are
// queued when a scenario is launched and compared as each clock edge elapses.
module tb_irq_timer;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  irq_timer_if bus ();

  irq_timer #(.PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          has_cnt;
    logic [31:0] cnt;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.we    = 1'b1;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  task automatic push(input string tag, input bit has_cnt, input logic [31:0] cnt, input logic irq);
    exp_t e;
    e.tag     = tag;
    e.has_cnt = has_cnt;
    e.cnt     = cnt;
    e.irq     = irq;
    sb.push_back(e);
  endtask

  // One clock edge per queued entry; compare COUNT (if expected) and irq.
  task automatic drain();
    exp_t        e;
    logic [31:0] v;
    while (sb.size() != 0) begin
      step();
      e = sb.pop_front();
      if (e.has_cnt) begin
        rd(2'd2, v);
        check({e.tag, "_cnt"}, v, e.cnt);
      end
      check({e.tag, "_irq"}, {31'd0, bus.irq}, {31'd0, e.irq});
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          lat;
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk_irq("rst_irq", 1'b0);
    rd(2'd0, v); check("rst_ctrl", v, 32'd0);
    rd(2'd1, v); check("rst_preset", v, 32'd0);
    rd(2'd2, v); check("rst_count", v, 32'd0);
    wr(2'd2, 32'h55);
    rd(2'd2, v); check("count_ro", v, 32'd0);

    // One-shot, PRESET = 3: COUNT 3,2,1,0 at e2..e5, irq held from e5
    wr(2'd1, 32'd3);
    rd(2'd1, v); check("preset_rd", v, 32'd3);
    rd(2'd3, v); check("reserved_rd", v, 32'd0);
    wr(2'd0, 32'h9);
    push("A_e1", 1'b0, '0, 1'b0);
    for (int k = 0; k < 4; k++)
      push($sformatf("A_e%0d", k + 2), 1'b1, 32'(3 - k), (k == 3));
    drain();
    step();
    chk_irq("A_e6_irq", 1'b1);
    rd(2'd0, v); check("A_e6_ctrl", v, 32'h8);
    step();
    chk_irq("A_e7_irq", 1'b1);
    wr(2'd0, 32'h0);
    chk_irq("A_ack_irq", 1'b0);

    // Auto-reload, PRESET = 2: period 3, one-cycle irq pulse, 4 periods
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    push("B_e1", 1'b0, '0, 1'b0);
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 3; k++)
        push($sformatf("B_p%0d_%0d", p, k), 1'b1, 32'(2 - k), (k == 2));
    drain();
    step();
    chk_irq("B_after_irq", 1'b0);
    rd(2'd2, v); check("B_after_cnt", v, 32'd2);
    wr(2'd0, 32'h0);
    step();

    // Masked interrupt, PRESET = 1: irq never rises; CTRL write clears flag
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    push("C_e1", 1'b0, '0, 1'b0);
    push("C_e2", 1'b1, 32'd1, 1'b0);
    push("C_e3", 1'b1, 32'd0, 1'b0);
    push("C_e4", 1'b1, 32'd0, 1'b0);
    push("C_e5", 1'b1, 32'd0, 1'b0);
    drain();
    wr(2'd0, 32'h8);
    chk_irq("C_unmask_irq", 1'b0);
    step();
    chk_irq("C_unmask_irq2", 1'b0);

    // PRESET = 0 expires at e3; CTRL write on that edge loses to the flag set
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step();
    step();
    rd(2'd2, v); check("D_e2_cnt", v, 32'd0);
    chk_irq("D_e2_irq", 1'b0);
    wr(2'd0, 32'h9);
    chk_irq("D_e3_irq", 1'b1);
    wr(2'd0, 32'h9);
    rd(2'd0, v); check("D_e4_ctrl", v, 32'h9);
    chk_irq("D_e4_irq", 1'b0);
    step();
    step();
    chk_irq("D_e6_irq", 1'b0);
    step();
    chk_irq("D_e7_irq", 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_irq("D_async_irq", 1'b0);
    rd(2'd0, v); check("D_async_ctrl", v, 32'd0);
    reset = 1'b0;

    // Asynchronous reset mid-count with COUNT = 5
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (7) step();
    rd(2'd2, v); check("E_cnt5", v, 32'd5);
    #1;
    reset = 1'b1;
    #1;
    rd(2'd2, v); check("E_async_cnt", v, 32'd0);
    rd(2'd1, v); check("E_async_preset", v, 32'd0);
    chk_irq("E_async_irq", 1'b0);
    reset = 1'b0;

    // Prescale latency, PRESET = 2
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
`ifdef TIMER_PRESCALE_EN
    lat = 2 + 2 * 4;
`else
    lat = 4;
`endif
    for (int k = 1; k <= lat; k++)
      push($sformatf("F_e%0d", k), 1'b0, '0, (k == lat));
    drain();
    step();
    chk_irq("F_hold_irq", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
